// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the memory-bus router.
// FSM state and decoded-region enums, GPIO register offsets.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STOR_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic [2:0] {
        REG_GPIO,
        REG_TIMER,
        REG_SRAM,
        REG_EXT,
        REG_RSVD
    } region_t;

    // Byte offsets of the GPIO registers from GPIO_BASE
    localparam logic [3:0] GPIO_OFF_DIR = 4'h0;
    localparam logic [3:0] GPIO_OFF_OUT = 4'h4;
    localparam logic [3:0] GPIO_OFF_IN  = 4'h8;

endpackage

// File: rtl/mem_bus_gpio_regs.sv
// mem_bus_gpio_regs: GPIO DIR/OUT registers with byte-masked writes,
// 2-flop input synchroniser and register read mux.
// i_widx is the word index (byte offset [3:2]) within the GPIO block.
module mem_bus_gpio_regs
    import mem_bus_pkg::*;
#(
    parameter int unsigned N_GPIO = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_we,
    input  logic [1:0]                  i_widx,
    input  logic [(N_GPIO+7)/8-1:0]     i_be,
    input  logic [N_GPIO-1:0]           i_wdata,
    output logic [N_GPIO-1:0]           o_rdata,
    input  logic [N_GPIO-1:0]           gpio_in,
    output logic [N_GPIO-1:0]           gpio_out,
    output logic [N_GPIO-1:0]           gpio_oe
);

    logic [N_GPIO-1:0] r_dir;
    logic [N_GPIO-1:0] r_out;
    logic [N_GPIO-1:0] r_sync1;
    logic [N_GPIO-1:0] r_sync2;
    logic [N_GPIO-1:0] w_mask;

    // Expand byte enables into a per-bit write mask
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < N_GPIO; i++) begin
            w_mask[i] = i_be[i/8];
        end
    end

    // Register state: DIR/OUT writes and the pad-input synchroniser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir   <= '1;
            r_out   <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            if (i_we && i_widx == GPIO_OFF_DIR[3:2]) begin
                r_dir <= (r_dir & ~w_mask) | (i_wdata & w_mask);
            end
            if (i_we && i_widx == GPIO_OFF_OUT[3:2]) begin
                r_out <= (r_out & ~w_mask) | (i_wdata & w_mask);
            end
        end
    end

    // Read mux over the three registers
    always_comb begin
        o_rdata = '0;
        case (i_widx)
            GPIO_OFF_DIR[3:2]: o_rdata = r_dir;
            GPIO_OFF_OUT[3:2]: o_rdata = r_out;
            GPIO_OFF_IN[3:2]:  o_rdata = r_sync2;
            default:           o_rdata = '0;
        endcase
    end

    assign gpio_out = r_out;
    assign gpio_oe  = ~r_dir;

endmodule

// File: rtl/mem_bus_router.sv
// mem_bus_router: routes the Vicuna/Ibex data port to GPIO, timer,
// SRAM scratch and external storage, one transaction outstanding.
// Optional feature macro: MEM_BUS_TIMEOUT_EN (storage wait timeout).
module mem_bus_router
    import mem_bus_pkg::*;
#(
    parameter int unsigned MEM_W          = 32,
    parameter int unsigned N_GPIO         = 10,
    parameter logic [31:0] GPIO_BASE      = 32'h0000_0100,
    parameter logic [31:0] TIMER_BASE     = 32'h0000_0110,
    parameter logic [31:0] SRAM_BASE      = 32'h0000_1000,
    parameter logic [31:0] EXT_BASE       = 32'h0000_2000,
    parameter bit          EXT_READ_ONLY  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vproc_mem_req_o,
    output logic                 vproc_mem_gnt_i,
    input  logic [31:0]          vproc_mem_addr_o,
    input  logic                 vproc_mem_we_o,
    input  logic [MEM_W/8-1:0]   vproc_mem_be_o,
    input  logic [MEM_W-1:0]     vproc_mem_wdata_o,
    output logic                 vproc_mem_rvalid_i,
    output logic                 vproc_mem_err_i,
    output logic [MEM_W-1:0]     vproc_mem_rdata_i,
    output logic                 stor_req,
    output logic                 stor_we,
    output logic [31:0]          stor_addr,
    output logic [MEM_W/8-1:0]   stor_be,
    output logic [MEM_W-1:0]     stor_wdata,
    input  logic [MEM_W-1:0]     stor_rdata,
    input  logic                 stor_valid,
    input  logic                 timer_is_high,
    output logic [31:0]          timer_set_val,
    output logic                 set_timer,
    input  logic [N_GPIO-1:0]    gpio_in,
    output logic [N_GPIO-1:0]    gpio_out,
    output logic [N_GPIO-1:0]    gpio_oe
);

    localparam int unsigned GB = (N_GPIO + 7) / 8;

    state_t              r_state;
    logic                r_gnt;
    logic                r_rvalid;
    logic                r_err;
    logic [MEM_W-1:0]    r_rdata;
    logic                r_stor_req;
    logic                r_stor_we;
    logic [31:0]         r_stor_addr;
    logic [MEM_W/8-1:0]  r_stor_be;
    logic [MEM_W-1:0]    r_stor_wdata;
    logic                r_set_timer;
    logic [31:0]         r_timer_set_val;

    region_t             w_region;
    logic                w_accept;
    logic                w_misal;
    logic [1:0]          w_widx;
    logic                w_fault;
    logic                w_is_stor;
    logic                w_gpio_we;
    logic [N_GPIO-1:0]   w_gpio_rd;
    logic [MEM_W-1:0]    w_rd;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]    r_tmo;
`endif

    // GPIO_BASE is word aligned, so a 2-bit subtract yields offset[3:2] exactly
    assign w_widx   = vproc_mem_addr_o[3:2] - GPIO_BASE[3:2];
    assign w_misal  = (vproc_mem_addr_o[1:0] != 2'b00);
    assign w_accept = vproc_mem_req_o & r_gnt;

    // Region decode in priority order GPIO, TIMER, SRAM, EXT, reserved
    always_comb begin
        w_region = REG_RSVD;
        if (vproc_mem_addr_o >= GPIO_BASE && vproc_mem_addr_o <= GPIO_BASE + 32'h0000_000B)
            w_region = REG_GPIO;
        else if (vproc_mem_addr_o[31:2] == TIMER_BASE[31:2])
            w_region = REG_TIMER;
        else if (vproc_mem_addr_o >= SRAM_BASE && vproc_mem_addr_o < EXT_BASE)
            w_region = REG_SRAM;
        else if (vproc_mem_addr_o >= EXT_BASE)
            w_region = REG_EXT;
    end

    // Fault classification and register read data for the presented request
    always_comb begin
        w_fault   = 1'b0;
        w_is_stor = 1'b0;
        w_rd      = '0;
        case (w_region)
            REG_GPIO: begin
                w_fault = w_misal ||
                          (vproc_mem_we_o && w_widx == GPIO_OFF_IN[3:2]);
                w_rd[N_GPIO-1:0] = w_gpio_rd;
            end
            REG_TIMER: begin
                w_fault = w_misal;
                w_rd[0] = timer_is_high;
            end
            REG_SRAM: begin
                w_is_stor = 1'b1;
            end
            REG_EXT: begin
                w_fault   = EXT_READ_ONLY && vproc_mem_we_o;
                w_is_stor = !w_fault;
            end
            default: begin
                w_fault = 1'b1;
            end
        endcase
    end

    assign w_gpio_we = w_accept && (w_region == REG_GPIO) && !w_fault && vproc_mem_we_o;

    mem_bus_gpio_regs #(
        .N_GPIO (N_GPIO)
    ) u_gpio (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_gpio_we),
        .i_widx   (w_widx),
        .i_be     (vproc_mem_be_o[GB-1:0]),
        .i_wdata  (vproc_mem_wdata_o[N_GPIO-1:0]),
        .o_rdata  (w_gpio_rd),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe)
    );

    // Transaction FSM with registered bus, storage and timer outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_gnt           <= 1'b1;
            r_rvalid        <= 1'b0;
            r_err           <= 1'b0;
            r_rdata         <= '0;
            r_stor_req      <= 1'b0;
            r_stor_we       <= 1'b0;
            r_stor_addr     <= '0;
            r_stor_be       <= '0;
            r_stor_wdata    <= '0;
            r_set_timer     <= 1'b0;
            r_timer_set_val <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
            r_tmo           <= '0;
`endif
        end else begin
            r_set_timer <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_gnt <= 1'b0;
                        if (w_fault) begin
                            r_state  <= ST_RESP;
                            r_rvalid <= 1'b1;
                            r_err    <= 1'b1;
                            r_rdata  <= '0;
                        end else if (w_is_stor) begin
                            r_state      <= ST_STOR_WAIT;
                            r_stor_req   <= 1'b1;
                            r_stor_we    <= vproc_mem_we_o;
                            r_stor_addr  <= vproc_mem_addr_o;
                            r_stor_be    <= vproc_mem_be_o;
                            r_stor_wdata <= vproc_mem_wdata_o;
`ifdef MEM_BUS_TIMEOUT_EN
                            r_tmo        <= '0;
`endif
                        end else begin
                            r_state  <= ST_RESP;
                            r_rvalid <= 1'b1;
                            r_err    <= 1'b0;
                            r_rdata  <= vproc_mem_we_o ? '0 : w_rd;
                            if (w_region == REG_TIMER && vproc_mem_we_o) begin
                                r_set_timer     <= 1'b1;
                                r_timer_set_val <= vproc_mem_wdata_o[31:0];
                            end
                        end
                    end
                end
                ST_STOR_WAIT: begin
                    if (stor_valid) begin
                        r_state    <= ST_RESP;
                        r_stor_req <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_err      <= 1'b0;
                        r_rdata    <= r_stor_we ? '0 : stor_rdata;
                    end
`ifdef MEM_BUS_TIMEOUT_EN
                    else if (r_tmo == TMO_LAST) begin
                        r_state    <= ST_RESP;
                        r_stor_req <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_err      <= 1'b1;
                        r_rdata    <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    r_state  <= ST_IDLE;
                    r_gnt    <= 1'b1;
                    r_rvalid <= 1'b0;
                    r_err    <= 1'b0;
                    r_rdata  <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 1'b1;
                end
            endcase
        end
    end

    assign vproc_mem_gnt_i    = r_gnt;
    assign vproc_mem_rvalid_i = r_rvalid;
    assign vproc_mem_err_i    = r_err;
    assign vproc_mem_rdata_i  = r_rdata;
    assign stor_req           = r_stor_req;
    assign stor_we            = r_stor_we;
    assign stor_addr          = r_stor_addr;
    assign stor_be            = r_stor_be;
    assign stor_wdata         = r_stor_wdata;
    assign set_timer          = r_set_timer;
    assign timer_set_val      = r_timer_set_val;

endmodule

// File: tb/tb_mem_bus_router.sv
// tb_mem_bus_router: directed self-checking bench for mem_bus_router.
// Honours MEM_BUS_TIMEOUT_EN to select the storage-timeout scenario.
module tb_mem_bus_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
    logic        stor_req;
    logic        stor_we;
    logic [31:0] stor_addr;
    logic [3:0]  stor_be;
    logic [31:0] stor_wdata;
    logic [31:0] stor_rdata;
    logic        stor_valid;
    logic        timer_is_high;
    logic [31:0] timer_set_val;
    logic        set_timer;
    logic [9:0]  gpio_in;
    logic [9:0]  gpio_out;
    logic [9:0]  gpio_oe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_router #(
        .MEM_W          (32),
        .N_GPIO         (10),
        .GPIO_BASE      (32'h0000_0100),
        .TIMER_BASE     (32'h0000_0110),
        .SRAM_BASE      (32'h0000_1000),
        .EXT_BASE       (32'h0000_2000),
        .EXT_READ_ONLY  (1'b1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .vproc_mem_req_o    (req),
        .vproc_mem_gnt_i    (gnt),
        .vproc_mem_addr_o   (addr),
        .vproc_mem_we_o     (we),
        .vproc_mem_be_o     (be),
        .vproc_mem_wdata_o  (wdata),
        .vproc_mem_rvalid_i (rvalid),
        .vproc_mem_err_i    (err),
        .vproc_mem_rdata_i  (rdata),
        .stor_req           (stor_req),
        .stor_we            (stor_we),
        .stor_addr          (stor_addr),
        .stor_be            (stor_be),
        .stor_wdata         (stor_wdata),
        .stor_rdata         (stor_rdata),
        .stor_valid         (stor_valid),
        .timer_is_high      (timer_is_high),
        .timer_set_val      (timer_set_val),
        .set_timer          (set_timer),
        .gpio_in            (gpio_in),
        .gpio_out           (gpio_out),
        .gpio_oe            (gpio_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge of cycle T+1
    task automatic issue(input string tag, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        check({tag, "_gnt_pre"}, 32'(gnt), 32'd1);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    endtask

    // Response checks at T+1 for register or fault accesses
    task automatic resp(input string tag, input logic exp_err, input logic [31:0] exp_rd);
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_rdata"}, rdata, exp_rd);
        check({tag, "_gnt_busy"}, 32'(gnt), 32'd0);
        check({tag, "_no_stor"}, 32'(stor_req), 32'd0);
    endtask

    // T+2: back in IDLE
    task automatic idle_back(input string tag);
        @(negedge clk);
        check({tag, "_rvalid_off"}, 32'(rvalid), 32'd0);
        check({tag, "_gnt_back"}, 32'(gnt), 32'd1);
        check({tag, "_no_stor2"}, 32'(stor_req), 32'd0);
    endtask

    task automatic reg_txn(input string tag, input logic w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d,
                           input logic exp_err, input logic [31:0] exp_rd);
        issue(tag, w, a, b, d);
        resp(tag, exp_err, exp_rd);
        idle_back(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
        stor_rdata = '0; stor_valid = 1'b0; timer_is_high = 1'b0; gpio_in = 10'h155;
        repeat (2) @(negedge clk);
        check("rst_stor_req", 32'(stor_req), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd1);
        check("rst_gpio_oe", 32'(gpio_oe), 32'd0);
        check("rst_gpio_out", 32'(gpio_out), 32'd0);
        check("rst_set_timer", 32'(set_timer), 32'd0);
        check("rst_timer_val", timer_set_val, 32'd0);

        // GPIO
        reg_txn("rd_dir_rst", 1'b0, 32'h100, 4'hF, 0, 1'b0, 32'h3FF);
        issue("wr_dir0", 1'b1, 32'h100, 4'hF, 32'h0);
        resp("wr_dir0", 1'b0, 32'h0);
        check("wr_dir0_oe", 32'(gpio_oe), 32'h3FF);
        idle_back("wr_dir0");
        issue("wr_out", 1'b1, 32'h104, 4'hF, 32'h2A5);
        resp("wr_out", 1'b0, 32'h0);
        check("wr_out_pins", 32'(gpio_out), 32'h2A5);
        idle_back("wr_out");
        reg_txn("wr_in_fault", 1'b1, 32'h108, 4'hF, 32'h3FF, 1'b1, 32'h0);
        reg_txn("wr_misal", 1'b1, 32'h102, 4'hF, 32'h0, 1'b1, 32'h0);
        check("faults_no_effect", 32'(gpio_out), 32'h2A5);
        // byte-masked write: only byte 1 (bits 9:8) updates
        reg_txn("wr_out_be", 1'b1, 32'h104, 4'h2, 32'hFFFF_FFFF, 1'b0, 32'h0);
        reg_txn("rd_out", 1'b0, 32'h104, 4'hF, 0, 1'b0, 32'h3A5);
        reg_txn("rd_in", 1'b0, 32'h108, 4'hF, 0, 1'b0, 32'h155);
        reg_txn("rd_dir0", 1'b0, 32'h100, 4'hF, 0, 1'b0, 32'h0);
        reg_txn("wr_dir_all", 1'b1, 32'h100, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0);
        reg_txn("rd_dir_all", 1'b0, 32'h100, 4'hF, 0, 1'b0, 32'h3FF);
        check("dir_all_oe", 32'(gpio_oe), 32'h0);

        // SRAM read with delayed completion
        issue("sram_rd", 1'b0, 32'h1004, 4'hF, 0);
        check("sram_rd_req", 32'(stor_req), 32'd1);
        check("sram_rd_addr", stor_addr, 32'h1004);
        check("sram_rd_we", 32'(stor_we), 32'd0);
        check("sram_rd_be", 32'(stor_be), 32'hF);
        for (int i = 0; i < 4; i++) begin
            check("sram_rd_wait_gnt", 32'(gnt), 32'd0);
            check("sram_rd_wait_rv", 32'(rvalid), 32'd0);
            check("sram_rd_wait_req", 32'(stor_req), 32'd1);
            if (i < 3) @(negedge clk);
        end
        stor_valid = 1'b1; stor_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        stor_valid = 1'b0; stor_rdata = '0;
        check("sram_rd_rvalid", 32'(rvalid), 32'd1);
        check("sram_rd_rdata", rdata, 32'hDEAD_BEEF);
        check("sram_rd_err", 32'(err), 32'd0);
        check("sram_rd_req_drop", 32'(stor_req), 32'd0);
        check("sram_rd_gnt", 32'(gnt), 32'd0);
        idle_back("sram_rd");

        // stray stor_valid in IDLE is ignored
        stor_valid = 1'b1;
        @(negedge clk);
        stor_valid = 1'b0;
        check("stray_valid_rv", 32'(rvalid), 32'd0);
        check("stray_valid_gnt", 32'(gnt), 32'd1);

        // SRAM write completing immediately
        issue("sram_wr", 1'b1, 32'h1008, 4'h3, 32'h1234_5678);
        check("sram_wr_we", 32'(stor_we), 32'd1);
        check("sram_wr_wdata", stor_wdata, 32'h1234_5678);
        check("sram_wr_be", 32'(stor_be), 32'h3);
        stor_valid = 1'b1; stor_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        stor_valid = 1'b0; stor_rdata = '0;
        check("sram_wr_rvalid", 32'(rvalid), 32'd1);
        check("sram_wr_rdata", rdata, 32'h0);
        idle_back("sram_wr");

        // EXT: write faults, read goes to storage; reserved faults
        reg_txn("ext_wr", 1'b1, 32'h3000, 4'hF, 32'h55, 1'b1, 32'h0);
        issue("ext_rd", 1'b0, 32'hFFFF_FFFC, 4'hF, 0);
        check("ext_rd_req", 32'(stor_req), 32'd1);
        check("ext_rd_addr", stor_addr, 32'hFFFF_FFFC);
        stor_valid = 1'b1; stor_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        stor_valid = 1'b0;
        check("ext_rd_rdata", rdata, 32'hCAFE_F00D);
        idle_back("ext_rd");
        reg_txn("rsvd_rd", 1'b0, 32'h0800, 4'hF, 0, 1'b1, 32'h0);
        reg_txn("gpio_end_plus1", 1'b0, 32'h10C, 4'hF, 0, 1'b1, 32'h0);

        // Timer
        issue("tmr_wr", 1'b1, 32'h110, 4'hF, 32'h64);
        resp("tmr_wr", 1'b0, 32'h0);
        check("tmr_wr_strobe", 32'(set_timer), 32'd1);
        check("tmr_wr_val", timer_set_val, 32'h64);
        idle_back("tmr_wr");
        check("tmr_wr_strobe_off", 32'(set_timer), 32'd0);
        check("tmr_wr_val_hold", timer_set_val, 32'h64);
        timer_is_high = 1'b1;
        reg_txn("tmr_rd_hi", 1'b0, 32'h110, 4'hF, 0, 1'b0, 32'h1);
        timer_is_high = 1'b0;
        reg_txn("tmr_rd_lo", 1'b0, 32'h110, 4'hF, 0, 1'b0, 32'h0);
        reg_txn("tmr_misal", 1'b1, 32'h112, 4'hF, 32'h7, 1'b1, 32'h0);
        check("tmr_misal_no_strobe", 32'(set_timer), 32'd0);

        // Reset in the middle of STOR_WAIT
        issue("rst_mid", 1'b0, 32'h1000, 4'hF, 0);
        @(negedge clk);
        check("rst_mid_req_pre", 32'(stor_req), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_req_drop", 32'(stor_req), 32'd0);
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_no_rv", 32'(rvalid), 32'd0);
            check("rst_mid_gnt", 32'(gnt), 32'd1);
        end

`ifdef MEM_BUS_TIMEOUT_EN
        // Storage timeout after 16 wait cycles
        issue("tmo", 1'b0, 32'h1010, 4'hF, 0);
        n = 1;
        while (!rvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycle", 32'(n), 32'd17);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_req_drop", 32'(stor_req), 32'd0);
        check("tmo_rdata", rdata, 32'h0);
        @(negedge clk);
        stor_valid = 1'b1;
        @(negedge clk);
        stor_valid = 1'b0;
        check("tmo_late_rv", 32'(rvalid), 32'd0);
        check("tmo_late_gnt", 32'(gnt), 32'd1);
`else
        // Without the timeout the router waits indefinitely
        issue("notmo", 1'b0, 32'h1010, 4'hF, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (rvalid) n++;
            @(negedge clk);
        end
        check("notmo_no_rv", 32'(n), 32'd0);
        check("notmo_req_held", 32'(stor_req), 32'd1);
        stor_valid = 1'b1; stor_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        stor_valid = 1'b0;
        check("notmo_rdata", rdata, 32'h0BAD_F00D);
        check("notmo_err", 32'(err), 32'd0);
        idle_back("notmo");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
